// File: rtl/xadc_drp_config_arbiter.sv
// Owns the XADC DRP port: writes the configuration table after reset or on request,
// and lends the port to a single read client in between.
module xadc_drp_config_arbiter #(
  parameter int unsigned STARTUP_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [15:0] CFG_REG0       = 16'h0000,
  parameter logic [15:0] CFG_REG1       = 16'h2000,
  parameter logic [15:0] CFG_REG2       = 16'h0400,
  parameter logic [15:0] SEQ_CHSEL1     = 16'h1010,
  parameter logic [15:0] SEQ_AVG1       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  client_daddr,
  input  logic        client_den,
  output logic        client_gnt,
  output logic        client_drdy,
  output logic [15:0] client_do,
  output logic        client_eos,
  output logic [6:0]  xadc_daddr,
  output logic        xadc_den,
  output logic        xadc_dwe,
  output logic [15:0] xadc_di,
  input  logic        xadc_drdy,
  input  logic [15:0] xadc_do,
  input  logic        xadc_eos,
  input  logic        reconfig_req,
  output logic        config_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CNT_MAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'd4;

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_CLIENT,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic             cfg_step;

  logic [6:0]  xadc_daddr_d;
  logic        xadc_den_d;
  logic        xadc_dwe_d;
  logic [15:0] xadc_di_d;
  logic        client_gnt_d;
  logic        client_drdy_d;
  logic [15:0] client_do_d;
  logic        client_eos_d;
  logic        config_done_d;
  logic        busy_d;
  logic        timeout_err_d;

  logic [6:0]  cfg_addr;
  logic [15:0] cfg_data;

  function automatic logic [22:0] table_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    table_entry = {7'h40, CFG_REG0};
      3'd1:    table_entry = {7'h41, CFG_REG1};
      3'd2:    table_entry = {7'h42, CFG_REG2};
      3'd3:    table_entry = {7'h49, SEQ_CHSEL1};
      default: table_entry = {7'h4B, SEQ_AVG1};
    endcase
  endfunction

  assign {cfg_addr, cfg_data} = table_entry(idx_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_STARTUP;
      idx_q       <= '0;
      cnt_q       <= '0;
      rd_pend_q   <= 1'b0;
      xadc_daddr  <= '0;
      xadc_den    <= 1'b0;
      xadc_dwe    <= 1'b0;
      xadc_di     <= '0;
      client_gnt  <= 1'b0;
      client_drdy <= 1'b0;
      client_do   <= '0;
      client_eos  <= 1'b0;
      config_done <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rd_pend_q   <= rd_pend_d;
      xadc_daddr  <= xadc_daddr_d;
      xadc_den    <= xadc_den_d;
      xadc_dwe    <= xadc_dwe_d;
      xadc_di     <= xadc_di_d;
      client_gnt  <= client_gnt_d;
      client_drdy <= client_drdy_d;
      client_do   <= client_do_d;
      client_eos  <= client_eos_d;
      config_done <= config_done_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Every output is the registered image of the values computed here for the next state.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    rd_pend_d     = rd_pend_q;
    cfg_step      = 1'b0;
    xadc_daddr_d  = xadc_daddr;
    xadc_den_d    = 1'b0;
    xadc_dwe_d    = 1'b0;
    xadc_di_d     = xadc_di;
    client_drdy_d = 1'b0;
    client_do_d   = client_do;
    config_done_d = config_done;
    timeout_err_d = timeout_err;

    unique case (state_q)
      ST_STARTUP: begin
        if (cnt_q == STARTUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_CFG_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CFG_ISSUE: begin
        xadc_den_d   = 1'b1;
        xadc_dwe_d   = 1'b1;
        xadc_daddr_d = cfg_addr;
        xadc_di_d    = cfg_data;
        cnt_d        = '0;
        state_d      = ST_CFG_WAIT;
      end

      ST_CFG_WAIT: begin
        if (xadc_drdy) begin
          cfg_step = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cfg_step      = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cfg_step) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d         = '0;
            config_done_d = 1'b1;
            state_d       = ST_CLIENT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_CFG_ISSUE;
          end
        end
      end

      ST_CLIENT: begin
        if (rd_pend_q) begin
          if (xadc_drdy) begin
            client_drdy_d = 1'b1;
            client_do_d   = xadc_do;
            rd_pend_d     = 1'b0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            timeout_err_d = 1'b1;
            rd_pend_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (client_den && client_gnt) begin
          xadc_den_d   = 1'b1;
          xadc_dwe_d   = 1'b0;
          xadc_daddr_d = client_daddr;
          rd_pend_d    = 1'b1;
          cnt_d        = '0;
        end
        // A read accepted on this same edge still counts as in flight and must drain.
        if (reconfig_req) begin
          state_d = rd_pend_d ? ST_DRAIN : ST_CFG_ISSUE;
        end
      end

      ST_DRAIN: begin
        if (xadc_drdy) begin
          client_drdy_d = 1'b1;
          client_do_d   = xadc_do;
          rd_pend_d     = 1'b0;
          state_d       = ST_CFG_ISSUE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_err_d = 1'b1;
          rd_pend_d     = 1'b0;
          state_d       = ST_CFG_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_STARTUP;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    client_gnt_d = (state_d == ST_CLIENT);
    busy_d       = (state_d != ST_CLIENT);
    // Suppress end-of-sequence on the edges entering or leaving CLIENT as well.
    client_eos_d = xadc_eos && (state_q == ST_CLIENT) && (state_d == ST_CLIENT);
  end

endmodule

// File: tb/tb_xadc_drp_config_arbiter.sv
// Drives the arbiter with directed and random traffic, acting as the XADC, and
// compares every registered output against a transaction-level model each cycle.
module tb_xadc_drp_config_arbiter;

  localparam int STARTUP = 16;
  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic [6:0]  client_daddr;
  logic        client_den;
  logic        client_gnt;
  logic        client_drdy;
  logic [15:0] client_do;
  logic        client_eos;
  logic [6:0]  xadc_daddr;
  logic        xadc_den;
  logic        xadc_dwe;
  logic [15:0] xadc_di;
  logic        xadc_drdy;
  logic [15:0] xadc_do;
  logic        xadc_eos;
  logic        reconfig_req;
  logic        config_done;
  logic        busy;
  logic        timeout_err;

  xadc_drp_config_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .client_daddr (client_daddr),
    .client_den   (client_den),
    .client_gnt   (client_gnt),
    .client_drdy  (client_drdy),
    .client_do    (client_do),
    .client_eos   (client_eos),
    .xadc_daddr   (xadc_daddr),
    .xadc_den     (xadc_den),
    .xadc_dwe     (xadc_dwe),
    .xadc_di      (xadc_di),
    .xadc_drdy    (xadc_drdy),
    .xadc_do      (xadc_do),
    .xadc_eos     (xadc_eos),
    .reconfig_req (reconfig_req),
    .config_done  (config_done),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_writes = 0;

  logic [22:0] cfg_table [0:4];

  // Reference model: pending table writes as a queue, timeouts as absolute deadlines.
  int          m_cyc = 0;
  int          m_boot = 0;
  bit          m_booting, m_issue, m_wwait, m_granted, m_rwait, m_drain, m_in_reset;
  int          m_wdead, m_rdead;
  logic [22:0] m_wq[$];
  logic        e_den, e_dwe, e_gnt, e_cdrdy, e_ceos, e_done, e_busy, e_tmo;
  logic [6:0]  e_daddr;
  logic [15:0] e_di, e_cdo;

  // XADC responder settings.
  int          resp_cd = 0;
  bit          rand_lat = 0;
  bit          drop_reads = 0;
  bit          resp_random = 1;
  logic [15:0] resp_do = 16'h0000;
  logic [6:0]  drop_addr = 7'h7F;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_read();
    if (xadc_drdy) begin
      e_cdrdy = 1'b1;
      e_cdo   = xadc_do;
      m_rwait = 1'b0;
    end else if (m_cyc == m_rdead) begin
      e_tmo   = 1'b1;
      m_rwait = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit was_granted;
    was_granted = m_granted;
    m_cyc++;
    e_den   = 1'b0;
    e_dwe   = 1'b0;
    e_cdrdy = 1'b0;
    if (!rst_n) begin
      m_in_reset = 1'b1;
      m_booting = 1'b1; m_boot = 0; m_issue = 1'b0; m_wwait = 1'b0;
      m_granted = 1'b0; m_rwait = 1'b0; m_drain = 1'b0;
      m_wq.delete();
      for (int i = 0; i < 5; i++) m_wq.push_back(cfg_table[i]);
      e_daddr = '0; e_di = '0; e_cdo = '0;
      e_done = 1'b0; e_tmo = 1'b0; e_gnt = 1'b0; e_busy = 1'b1; e_ceos = 1'b0;
      return;
    end
    m_in_reset = 1'b0;
    if (m_booting) begin
      m_boot++;
      if (m_boot == STARTUP) begin
        m_booting = 1'b0;
        m_issue   = 1'b1;
      end
    end else if (m_issue) begin
      e_den = 1'b1;
      e_dwe = 1'b1;
      {e_daddr, e_di} = m_wq[0];
      m_issue = 1'b0;
      m_wwait = 1'b1;
      m_wdead = m_cyc + TIMEOUT;
    end else if (m_wwait) begin
      if (xadc_drdy || m_cyc == m_wdead) begin
        if (!xadc_drdy) e_tmo = 1'b1;
        void'(m_wq.pop_front());
        m_wwait = 1'b0;
        if (m_wq.size() == 0) begin
          m_granted = 1'b1;
          e_done    = 1'b1;
          for (int i = 0; i < 5; i++) m_wq.push_back(cfg_table[i]);
        end else begin
          m_issue = 1'b1;
        end
      end
    end else if (m_granted) begin
      if (m_rwait) begin
        model_read();
      end else if (client_den) begin
        e_den   = 1'b1;
        e_dwe   = 1'b0;
        e_daddr = client_daddr;
        m_rwait = 1'b1;
        m_rdead = m_cyc + TIMEOUT;
      end
      if (reconfig_req) begin
        m_granted = 1'b0;
        if (m_rwait) m_drain = 1'b1;
        else m_issue = 1'b1;
      end
    end else if (m_drain) begin
      model_read();
      if (!m_rwait) begin
        m_drain = 1'b0;
        m_issue = 1'b1;
      end
    end
    e_gnt  = m_granted;
    e_busy = !m_granted;
    e_ceos = was_granted && m_granted && xadc_eos;
  endtask

  task automatic check_all();
    check_output("xadc_den", 32'(xadc_den), 32'(e_den));
    check_output("xadc_dwe", 32'(xadc_dwe), 32'(e_dwe));
    if (e_den || m_in_reset) check_output("xadc_daddr", 32'(xadc_daddr), 32'(e_daddr));
    if ((e_den && e_dwe) || m_in_reset) check_output("xadc_di", 32'(xadc_di), 32'(e_di));
    check_output("client_gnt", 32'(client_gnt), 32'(e_gnt));
    check_output("client_drdy", 32'(client_drdy), 32'(e_cdrdy));
    check_output("client_do", 32'(client_do), 32'(e_cdo));
    check_output("client_eos", 32'(client_eos), 32'(e_ceos));
    check_output("config_done", 32'(config_done), 32'(e_done));
    check_output("busy", 32'(busy), 32'(e_busy));
    check_output("timeout_err", 32'(timeout_err), 32'(e_tmo));
  endtask

  // Clears one-cycle pulses and plays the XADC side of the DRP handshake.
  task automatic apply_stimulus();
    client_den   = 1'b0;
    reconfig_req = 1'b0;
    xadc_eos     = 1'b0;
    xadc_drdy    = 1'b0;
    xadc_do      = resp_random ? 16'($urandom) : resp_do;
    if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) xadc_drdy = 1'b1;
    end
    if (xadc_den === 1'b1) begin
      if (xadc_daddr === drop_addr) begin
        resp_cd = 0;
      end else if (xadc_dwe === 1'b0 && drop_reads && $urandom_range(0, 15) == 0) begin
        resp_cd = 0;
      end else begin
        resp_cd = rand_lat ? int'($urandom_range(1, 6)) : 3;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (xadc_den === 1'b1 && xadc_dwe === 1'b1) dut_writes++;
    apply_stimulus();
  endtask

  task automatic check_startup();
    for (int k = 1; k <= 17; k++) begin
      if (k == 5) xadc_eos = 1'b1;
      tick();
      if (k == 16) check_output("den_before_startup_end", 32'(xadc_den), 32'd0);
    end
    check_output("first_den_cycle", 32'(xadc_den), 32'd1);
    check_output("first_den_addr", 32'(xadc_daddr), 32'h40);
  endtask

  task automatic wait_grant(input int limit, input string tag);
    int n;
    n = 0;
    while (client_gnt !== 1'b1 && n < limit) begin
      if ($urandom_range(0, 2) == 0) xadc_eos = 1'b1;
      tick();
      n++;
    end
    check_output({tag, "_grant"}, 32'(client_gnt), 32'd1);
  endtask

  initial begin
    int w0;
    int n;
    cfg_table[0] = {7'h40, 16'h0000};
    cfg_table[1] = {7'h41, 16'h2000};
    cfg_table[2] = {7'h42, 16'h0400};
    cfg_table[3] = {7'h49, 16'h1010};
    cfg_table[4] = {7'h4B, 16'h0000};
    rst_n = 1'b0; client_daddr = '0; client_den = 1'b0; xadc_drdy = 1'b0;
    xadc_do = '0; xadc_eos = 1'b0; reconfig_req = 1'b0;

    // Reset state, then the power-up table with a 3-cycle responder.
    tick();
    tick();
    check_output("reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    w0 = dut_writes;
    check_startup();
    wait_grant(200, "boot");
    check_output("boot_writes", 32'(dut_writes - w0), 32'd5);
    check_output("boot_done", 32'(config_done), 32'd1);

    // Directed client read.
    resp_random = 1'b0;
    resp_do = 16'hABC0;
    client_den = 1'b1;
    client_daddr = 7'h14;
    tick();
    check_output("read_den", 32'(xadc_den), 32'd1);
    check_output("read_dwe", 32'(xadc_dwe), 32'd0);
    check_output("read_addr", 32'(xadc_daddr), 32'h14);
    repeat (4) tick();
    check_output("read_drdy", 32'(client_drdy), 32'd1);
    check_output("read_data", 32'(client_do), 32'hABC0);
    xadc_eos = 1'b1;
    tick();
    check_output("eos_in_client", 32'(client_eos), 32'd1);

    // Random traffic, including reads that never answer and occasional reconfiguration.
    resp_random = 1'b1;
    rand_lat = 1'b1;
    drop_reads = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        client_den = 1'b1;
        client_daddr = 7'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 9) == 0) xadc_eos = 1'b1;
      if ($urandom_range(0, 59) == 0) reconfig_req = 1'b1;
      tick();
    end

    // Reconfiguration requested together with a client read.
    rand_lat = 1'b0;
    drop_reads = 1'b0;
    n = 0;
    while (!(client_gnt === 1'b1 && !m_rwait) && n < 300) begin
      tick();
      n++;
    end
    check_output("idle_before_reconfig", 32'(client_gnt), 32'd1);
    client_den = 1'b1;
    client_daddr = 7'h1C;
    reconfig_req = 1'b1;
    w0 = dut_writes;
    tick();
    check_output("reconfig_read_forwarded", 32'(xadc_daddr), 32'h1C);
    check_output("reconfig_gnt_drop", 32'(client_gnt), 32'd0);
    wait_grant(300, "reconfig");
    check_output("reconfig_writes", 32'(dut_writes - w0), 32'd5);

    // 0x41 never answers: timeout, table continues, error is sticky.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drop_addr = 7'h41;
    w0 = dut_writes;
    wait_grant(400, "timeout");
    check_output("timeout_writes", 32'(dut_writes - w0), 32'd5);
    check_output("timeout_set", 32'(timeout_err), 32'd1);
    repeat (10) tick();
    check_output("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset while waiting on the 0x42 write.
    drop_addr = 7'h7F;
    reconfig_req = 1'b1;
    tick();
    n = 0;
    while (!(xadc_den === 1'b1 && xadc_daddr === 7'h42) && n < 300) begin
      tick();
      n++;
    end
    check_output("reach_idx2", 32'(xadc_daddr), 32'h42);
    tick();
    rst_n = 1'b0;
    tick();
    check_output("midreset_done", 32'(config_done), 32'd0);
    check_output("midreset_tmo", 32'(timeout_err), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    check_startup();
    wait_grant(200, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
